// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard event controller: prefix FSM
// states, set-2 scan codes and the ASCII control characters it emits.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kbd_state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_BS = 8'h08;

  function automatic logic is_shift(input logic [7:0] c);
    return (c == SC_LSHIFT) || (c == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/kbd_scan2ascii.sv
// Combinational set-2 scan code to ASCII translation; letters are uppercased
// while shift is high, everything unmapped yields 8'h00.
module kbd_scan2ascii
  import kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] lower;

  always_comb begin
    lower = 8'h00;
    case (code)
      8'h1C: lower = "a";
      8'h32: lower = "b";
      8'h21: lower = "c";
      8'h23: lower = "d";
      8'h24: lower = "e";
      8'h2B: lower = "f";
      8'h34: lower = "g";
      8'h33: lower = "h";
      8'h43: lower = "i";
      8'h3B: lower = "j";
      8'h42: lower = "k";
      8'h4B: lower = "l";
      8'h3A: lower = "m";
      8'h31: lower = "n";
      8'h44: lower = "o";
      8'h4D: lower = "p";
      8'h15: lower = "q";
      8'h2D: lower = "r";
      8'h1B: lower = "s";
      8'h2C: lower = "t";
      8'h3C: lower = "u";
      8'h2A: lower = "v";
      8'h1D: lower = "w";
      8'h22: lower = "x";
      8'h35: lower = "y";
      8'h1A: lower = "z";
      8'h45: lower = "0";
      8'h16: lower = "1";
      8'h1E: lower = "2";
      8'h26: lower = "3";
      8'h25: lower = "4";
      8'h2E: lower = "5";
      8'h36: lower = "6";
      8'h3D: lower = "7";
      8'h3E: lower = "8";
      8'h46: lower = "9";
      SC_ENTER: lower = ASCII_CR;
      SC_SPACE: lower = ASCII_SP;
      SC_BKSP:  lower = ASCII_BS;
      default:  lower = 8'h00;
    endcase
  end

  assign ascii = (shift && lower >= "a" && lower <= "z") ? lower - 8'h20 : lower;

endmodule

// File: rtl/kbd_event_ctrl.sv
// Keyboard event controller: make/break/extended prefix FSM with timeout,
// typematic suppression, ASCII translation and an event FIFO.
// Optional Shift tracking is enabled by defining KBD_SHIFT_EN.
module kbd_event_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        code_valid,
  input  logic [7:0]                  code,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [7:0]                  evt_ascii,
  input  logic                        clr_ovf,
  output logic                        ovf,
  output logic                        shift_held,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int TO_LAST_I = TIMEOUT_CYC - 1;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];
  localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];

  kbd_state_t    state, state_nxt;
  logic [CW-1:0] to_cnt;
  logic          timeout;
  logic [7:0]    last_make;
  logic          shift_q;
  logic          is_sh;
  logic [7:0]    xl_ascii;

  logic lm_load, lm_clear, sh_set, sh_clr, push_req;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          full, pop, push;

`ifdef KBD_SHIFT_EN
  assign is_sh = is_shift(code);
`else
  assign is_sh = 1'b0;
`endif

  kbd_scan2ascii u_xlate (
    .code  (code),
    .shift (shift_q),
    .ascii (xl_ascii)
  );

  // A byte arriving on the final timeout cycle is still decoded in its prefix state.
  assign timeout = (state != ST_IDLE) && !code_valid && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (code_valid) begin
          if (code == SC_BREAK)    state_nxt = ST_BRK;
          else if (code == SC_EXT) state_nxt = ST_EXT;
        end
      end
      ST_BRK:     if (code_valid) state_nxt = ST_IDLE;
      ST_EXT:     if (code_valid) state_nxt = (code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
      ST_EXT_BRK: if (code_valid) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (timeout) state_nxt = ST_IDLE;
  end

  always_comb begin
    lm_load  = 1'b0;
    lm_clear = 1'b0;
    sh_set   = 1'b0;
    sh_clr   = 1'b0;
    push_req = 1'b0;
    if (code_valid) begin
      case (state)
        ST_IDLE: begin
          if (code != SC_BREAK && code != SC_EXT) begin
            if (is_sh) begin
              sh_set  = 1'b1;
              lm_load = 1'b1;
            end else if (code != last_make) begin
              lm_load  = 1'b1;
              push_req = (xl_ascii != 8'h00);
            end
          end
        end
        ST_BRK: begin
          lm_clear = (code == last_make);
          sh_clr   = is_sh;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt    <= '0;
      last_make <= 8'h00;
      shift_q   <= 1'b0;
    end else begin
      if (state_nxt == ST_IDLE || state_nxt != state) to_cnt <= '0;
      else                                            to_cnt <= to_cnt + 1'b1;
      if (lm_load)       last_make <= code;
      else if (lm_clear) last_make <= 8'h00;
      if (sh_set)      shift_q <= 1'b1;
      else if (sh_clr) shift_q <= 1'b0;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign full = (level == FULL_LVL);
  assign pop  = evt_valid && evt_ready;
  assign push = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push_req && !push) ovf <= 1'b1;
      else if (clr_ovf)      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= xl_ascii;
  end

  assign evt_valid  = (level != '0);
  assign evt_ascii  = evt_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_level = level;
  assign shift_held = shift_q;

endmodule

// File: doc/kbd_event_ctrl.md
# kbd_event_ctrl

Keyboard event controller between the PS/2 frame receiver and the VGA text writer. Consumes validated scan-code bytes, sequences make/break/extended prefixes, suppresses typematic repeats, tracks Shift, and translates presses to ASCII. Queues ASCII events in a small FIFO drained over a valid/ready handshake, so the display side never misses a keystroke.

## Interface
- FIFO_DEPTH, 8, event queue entries; power of two, 2..64
- TIMEOUT_CYC, 2000000, clk cycles a prefix state may wait for its next byte

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- code_valid  in  1  single-cycle pulse: code holds a parity/start/stop-checked byte
- code  in  8  scan code (set 2)
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts head when evt_valid && evt_ready
- evt_ascii  out  8  head ASCII; 8'h00 when empty
- clr_ovf  in  1  clears ovf
- ovf  out  1  sticky: an event was dropped on a full FIFO
- shift_held  out  1  current Shift state
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- Prefix FSM: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
- IDLE:
  - F0 goes to BRK; E0 goes to EXT.
  - 12/59 (Shift) sets shift and goes to last_make. No push.
  - code == last_make is typematic repeat and is ignored.
  - Any other code: last_make<=code, translate, push if ASCII ≠ 0.
- BRK on the next byte:
  - if code == last_make, last_make<=0.
  - if 12/59, shift clears; if both Shifts were pressed, shift clears on either release.
  - Returns to IDLE.
- EXT: F0 goes to EXT_BRK; any other byte is ignored and returns to IDLE. Extended keys never produce events.
- EXT_BRK: any byte returns to IDLE.
- Timeout: in BRK/EXT/EXT_BRK, a counter clears on entry and runs each cycle. Reaching TIMEOUT_CYC-1 forces IDLE without side effects. In IDLE the counter holds at 0.
- Translation:
  - letters 1C..1A map to 'a'..'z'; digits 45,16..46 map to '0'..'9'.
  - 5A maps to 0D, 29 to 20, 66 to 08.
  - All other codes map to 00.
- FIFO push/pop:
  - Push when FIFO not full, or when full with a same-cycle pop.
  - Otherwise the event is dropped and ovf is set.
  - ovf set has priority over clr_ovf in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level = push − pop count.
- Reset mid-frame or mid-prefix: everything returns to IDLE, FIFO empties, last_make = 0, shift = 0.

## Timing
- Reset values: evt_valid 0, evt_ascii 00, ovf 0, shift_held 0, fifo_level 0, FSM IDLE.
- Latency: code_valid at edge N with FIFO empty gives evt_valid=1 and evt_ascii valid after edge N+1.
- Pop takes effect at the accepting edge; the next head is visible the following cycle. Back-to-back pops give 1 event per cycle.
- evt_ascii and evt_valid are stable while evt_valid && !evt_ready.
- code_valid pulses arrive ≥2 cycles apart; behaviour for adjacent pulses is not required.
- Simultaneous push and pop on an empty FIFO: the push is accepted and the pop is ignored, since evt_valid was 0.

## Configuration
- KBD_SHIFT_EN defined:
  - Shift codes drive shift_held.
  - Letters emit uppercase (ASCII − 20h) while shift_held=1.
  - Digits are unaffected.
- Undefined:
  - shift_held is tied to 0.
  - 12/59 are treated as ordinary unmapped makes: they update last_make and never push.
  - All letters emit lowercase.

## Structure
- Package kbd_pkg:
  - FSM state enum.
  - Scan-code constants: F0, E0, 12, 59, 5A, 29, 66.
  - ASCII constants: 0D, 20, 08.
- Sub-module kbd_scan2ascii: combinational code plus shift to ASCII, one instance.
- FIFO storage, pointers, FSM and timeout counter live in the top.

## Test plan
- Send 1C then F0 1C; evt_ready=1 → exactly one event 61, fifo_level returns to 0, last_make=0.
- Send 1C repeated 5× (typematic), F0 1C, then 1C → two events 61.
- With KBD_SHIFT_EN: 12, 1C, F0 12, 1C (after F0 1C) → events 41 then 61; without the macro → 61, 61.
- Hold evt_ready=0 and send 9 distinct makes with FIFO_DEPTH=8 → fifo_level=8, ovf=1, head unchanged; pulse clr_ovf → ovf=0.
- Send E0 75 then E0 F0 75 → no events, FSM in IDLE; send F0 alone and wait TIMEOUT_CYC → IDLE, next 1B yields 73.
- Assert rst low mid-sequence after E0 with 3 queued events → evt_valid=0, fifo_level=0, next 2B yields 66 one cycle later.
